// File: rtl/and_operand_loader_if.sv
// and_operand_loader_if: byte-in / operand-pair-out handshake bundle for the AND operand loader
interface and_operand_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  modport master (output in_data, in_valid, out_ready, input in_ready, a, b, out_valid);
  modport slave  (input in_data, in_valid, out_ready, output in_ready, a, b, out_valid);
endinterface

// File: rtl/and_operand_loader.sv
// and_operand_loader: assembles two 16-bit operands from a byte stream and presents them to the AND array
module and_operand_loader #(
  parameter bit LSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 clr,
  and_operand_loader_if.slave bus
);
  typedef enum logic [2:0] {S_A0, S_A1, S_B0, S_B1, S_OUT} state_t;
  state_t      r_state;
  logic [15:0] r_a, r_b;
  logic        r_in_ready, r_out_valid;
  logic        w_xfer, w_lo;
  logic [15:0] w_a, w_b;
  assign w_xfer = bus.in_valid && r_in_ready;
  // first byte of an operand lands in the low lane only when LSB_FIRST
  assign w_lo = ((r_state == S_A0) || (r_state == S_B0)) == LSB_FIRST;
  assign w_a = w_lo ? {r_a[15:8], bus.in_data} : {bus.in_data, r_a[7:0]};
  assign w_b = w_lo ? {r_b[15:8], bus.in_data} : {bus.in_data, r_b[7:0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_A0;
      r_a         <= '0;
      r_b         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (clr) begin
      r_state     <= S_A0;
      r_a         <= '0;
      r_b         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else
      case (r_state)
        S_A0: if (w_xfer) begin r_a <= w_a; r_state <= S_A1; end
        S_A1: if (w_xfer) begin r_a <= w_a; r_state <= S_B0; end
        S_B0: if (w_xfer) begin r_b <= w_b; r_state <= S_B1; end
        S_B1: if (w_xfer) begin
          r_b         <= w_b;
          r_state     <= S_OUT;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b1;
        end
        S_OUT: if (bus.out_ready) begin
          r_state     <= S_A0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
        default: begin
          r_state     <= S_A0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.a         = r_a;
  assign bus.b         = r_b;
endmodule

// File: tb/tb_and_operand_loader.sv
// tb_and_operand_loader: vector table + scoreboard bench for the byte-serial AND operand loader
module tb_and_operand_loader;
  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  always #5 clk = ~clk;
  and_operand_loader_if if1 ();
  and_operand_loader_if if0 ();
  and_operand_loader #(.LSB_FIRST(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1.slave));
  and_operand_loader #(.LSB_FIRST(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if0.slave));
  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] ea, eb;
  } vec_t;
  typedef struct {
    logic [15:0] a, b;
  } pair_t;
  vec_t  tv [5];
  pair_t q [$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ho = -1;
  bit chk_rate = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // scoreboard: every handoff on the LSB-first loader must match the oldest pushed pair
  always @(negedge clk)
    if (if1.out_valid && if1.out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_handoff: got a=%h b=%h expected no handoff", if1.a, if1.b);
      end else begin
        pair_t p;
        p = q.pop_front();
        check("pair_a", {16'h0, if1.a}, {16'h0, p.a});
        check("pair_b", {16'h0, if1.b}, {16'h0, p.b});
        check("pair_and", {16'h0, if1.a & if1.b}, {16'h0, p.a & p.b});
      end
      if (chk_rate) begin
        if (last_ho >= 0) check("handoff_period", cyc - last_ho, 32'd5);
        last_ho = cyc;
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input bit sel, input logic [7:0] d);
    int t = 0;
    while (!(sel ? if0.in_ready : if1.in_ready) && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    if (sel) begin
      if0.in_data  = d;
      if0.in_valid = 1'b1;
    end else begin
      if1.in_data  = d;
      if1.in_valid = 1'b1;
    end
    tick();
  endtask
  task automatic send_vec(input vec_t v, input int maxgap);
    logic [7:0] by [4];
    by[0] = v.b0; by[1] = v.b1; by[2] = v.b2; by[3] = v.b3;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      if (g > 0) begin
        if1.in_valid = 1'b0;
        repeat (g) tick();
      end
      send(1'b0, by[i]);
    end
    q.push_back('{v.ea, v.eb});
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 100) begin
      tick();
      t++;
    end
    check("drain_queue_empty", q.size(), 32'd0);
  endtask
  initial begin
    tv[0] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 16'h1234, 16'hABCD};
    tv[1] = '{8'hFF, 8'h00, 8'h0F, 8'hF0, 16'h00FF, 16'hF00F};
    tv[2] = '{8'h55, 8'hAA, 8'h01, 8'h80, 16'hAA55, 16'h8001};
    tv[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000};
    tv[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 16'hBEEF, 16'hDEAD};
    rst_n = 1'b0;
    clr = 1'b0;
    if1.in_data = '0; if1.in_valid = 1'b0; if1.out_ready = 1'b0;
    if0.in_data = '0; if0.in_valid = 1'b0; if0.out_ready = 1'b0;
    #2;
    check("rst_out_valid", {31'h0, if1.out_valid}, 32'd0);
    check("rst_a", {16'h0, if1.a}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", {31'h0, if1.in_ready}, 32'd1);
    check("post_rst_out_valid", {31'h0, if1.out_valid}, 32'd0);
    check("post_rst_a", {16'h0, if1.a}, 32'h0);
    check("post_rst_b", {16'h0, if1.b}, 32'h0);
    send_vec(tv[0], 0);
    check("basic_out_valid", {31'h0, if1.out_valid}, 32'd1);
    check("basic_in_ready", {31'h0, if1.in_ready}, 32'd0);
    check("basic_a", {16'h0, if1.a}, 32'h1234);
    check("basic_b", {16'h0, if1.b}, 32'hABCD);
    check("basic_and", {16'h0, if1.a & if1.b}, 32'h0204);
    for (int i = 0; i < 10; i++) begin
      if1.in_data = 8'($urandom);
      if1.in_valid = 1'b1;
      tick();
      check("hold_a", {16'h0, if1.a}, 32'h1234);
      check("hold_b", {16'h0, if1.b}, 32'hABCD);
      check("hold_out_valid", {31'h0, if1.out_valid}, 32'd1);
    end
    if1.in_valid = 1'b0;
    if1.out_ready = 1'b1;
    drain();
    send(1'b1, 8'h12); send(1'b1, 8'h34); send(1'b1, 8'hAB); send(1'b1, 8'hCD);
    if0.in_valid = 1'b0;
    check("msb_out_valid", {31'h0, if0.out_valid}, 32'd1);
    check("msb_a", {16'h0, if0.a}, 32'h1234);
    check("msb_b", {16'h0, if0.b}, 32'hABCD);
    chk_rate = 1'b1;
    last_ho = -1;
    for (int i = 0; i < 3; i++) send_vec(tv[i], 0);
    if1.in_valid = 1'b0;
    drain();
    chk_rate = 1'b0;
    for (int i = 0; i < 5; i++) send_vec(tv[i], 3);
    if1.in_valid = 1'b0;
    drain();
    send(1'b0, 8'h34); send(1'b0, 8'h12);
    clr = 1'b1;
    if1.in_data = 8'h77;
    if1.in_valid = 1'b1;
    tick();
    clr = 1'b0;
    if1.in_valid = 1'b0;
    check("clr_a", {16'h0, if1.a}, 32'h0);
    check("clr_b", {16'h0, if1.b}, 32'h0);
    check("clr_in_ready", {31'h0, if1.in_ready}, 32'd1);
    check("clr_out_valid", {31'h0, if1.out_valid}, 32'd0);
    send_vec(tv[1], 0);
    if1.in_valid = 1'b0;
    drain();
    if1.out_ready = 1'b0;
    send(1'b0, 8'h55); send(1'b0, 8'hAA); send(1'b0, 8'h01); send(1'b0, 8'h80);
    if1.in_valid = 1'b0;
    check("pre_rst_out_valid", {31'h0, if1.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'h0, if1.out_valid}, 32'd0);
    check("async_rst_a", {16'h0, if1.a}, 32'h0);
    check("async_rst_in_ready", {31'h0, if1.in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    if1.out_ready = 1'b1;
    tick();
    send_vec(tv[4], 0);
    if1.in_valid = 1'b0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
